// File: rtl/axi_read_arbiter.sv
// Round-robin read arbiter that shares one AXI master port between the icache, dcache and uncached requesters.
// Only one read burst is in flight at a time. The write channel passes straight through from WRITE_MASTER.

package axi_read_arbiter_pkg;

    typedef struct packed {
        logic [31:0] araddr;
        logic [7:0]  arlen;
        logic [2:0]  arsize;
        logic [1:0]  arburst;
        logic        arvalid;
        logic        rready;
        logic [31:0] awaddr;
        logic [7:0]  awlen;
        logic [2:0]  awsize;
        logic [1:0]  awburst;
        logic        awvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wlast;
        logic        wvalid;
        logic        bready;
    } axi_req_t;

    typedef struct packed {
        logic        arready;
        logic        rvalid;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rlast;
        logic        awready;
        logic        wready;
        logic        bvalid;
        logic [1:0]  bresp;
    } axi_resp_t;

endpackage

module axi_read_arbiter
    import axi_read_arbiter_pkg::*;
#(
    parameter int  NUM_MASTERS  = 3,
    parameter int  WRITE_MASTER = 1,
    localparam int IDX_WIDTH    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  axi_req_t             m_axi_req  [NUM_MASTERS],
    output axi_resp_t            m_axi_resp [NUM_MASTERS],
    output axi_req_t             bus_axi_req,
    input  axi_resp_t            bus_axi_resp,
    output logic                 busy,
    output logic [IDX_WIDTH-1:0] grant_idx
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    state_t               state;
    logic [IDX_WIDTH-1:0] rr_ptr;
    logic [IDX_WIDTH-1:0] pick_idx;
    logic [IDX_WIDTH-1:0] next_ptr;
    logic                 pick_valid;
    axi_req_t             sel_req;
    logic                 ar_fire;
    logic                 r_done;
    logic                 req_unused;

    // First requester found when scanning from rr_ptr upward, wrapping at NUM_MASTERS.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (!pick_valid && m_axi_req[i].arvalid &&
                    ((int'(rr_ptr) + k) % NUM_MASTERS) == i) begin
                    pick_valid = 1'b1;
                    pick_idx   = IDX_WIDTH'(i);
                end
            end
        end
    end

    always_comb begin
        sel_req = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_idx == IDX_WIDTH'(i)) begin
                sel_req = m_axi_req[i];
            end
        end
    end

    // Write fields of the masters that are not WRITE_MASTER are deliberately ignored.
    always_comb begin
        req_unused = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            req_unused = req_unused ^ (^m_axi_req[i]);
        end
    end

    assign ar_fire  = (state == ADDR) && sel_req.arvalid && bus_axi_resp.arready;
    assign r_done   = (state == DATA) && bus_axi_resp.rvalid && sel_req.rready
                      && bus_axi_resp.rlast;
    assign next_ptr = (grant_idx == IDX_WIDTH'(NUM_MASTERS - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_idx <= pick_idx;
                        state     <= ADDR;
                        busy      <= 1'b1;
                    end
                end
                ADDR: begin
                    if (ar_fire) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (r_done) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        rr_ptr <= next_ptr;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // The valid/ready bits are gated by state, so an async reset drops them at once.
    always_comb begin
        bus_axi_req         = '0;
        bus_axi_req.araddr  = sel_req.araddr;
        bus_axi_req.arlen   = sel_req.arlen;
        bus_axi_req.arsize  = sel_req.arsize;
        bus_axi_req.arburst = sel_req.arburst;
        bus_axi_req.arvalid = (state == ADDR) && sel_req.arvalid;
        bus_axi_req.rready  = (state == DATA) && sel_req.rready;
        bus_axi_req.awaddr  = m_axi_req[WRITE_MASTER].awaddr;
        bus_axi_req.awlen   = m_axi_req[WRITE_MASTER].awlen;
        bus_axi_req.awsize  = m_axi_req[WRITE_MASTER].awsize;
        bus_axi_req.awburst = m_axi_req[WRITE_MASTER].awburst;
        bus_axi_req.awvalid = m_axi_req[WRITE_MASTER].awvalid;
        bus_axi_req.wdata   = m_axi_req[WRITE_MASTER].wdata;
        bus_axi_req.wstrb   = m_axi_req[WRITE_MASTER].wstrb;
        bus_axi_req.wlast   = m_axi_req[WRITE_MASTER].wlast;
        bus_axi_req.wvalid  = m_axi_req[WRITE_MASTER].wvalid;
        bus_axi_req.bready  = m_axi_req[WRITE_MASTER].bready;
    end

    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            m_axi_resp[i] = '0;
            if (grant_idx == IDX_WIDTH'(i)) begin
                m_axi_resp[i].arready = (state == ADDR) && bus_axi_resp.arready;
                if (state == DATA) begin
                    m_axi_resp[i].rvalid = bus_axi_resp.rvalid;
                    m_axi_resp[i].rdata  = bus_axi_resp.rdata;
                    m_axi_resp[i].rresp  = bus_axi_resp.rresp;
                    m_axi_resp[i].rlast  = bus_axi_resp.rlast;
                end
            end
            if (i == WRITE_MASTER) begin
                m_axi_resp[i].awready = bus_axi_resp.awready;
                m_axi_resp[i].wready  = bus_axi_resp.wready;
                m_axi_resp[i].bvalid  = bus_axi_resp.bvalid;
                m_axi_resp[i].bresp   = bus_axi_resp.bresp;
            end
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed testbench for axi_read_arbiter. The bench plays all three masters and the interconnect side.
// Expected values are hand-computed per scenario.

module tb_axi_read_arbiter;
    import axi_read_arbiter_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    axi_req_t  m_req  [3];
    axi_resp_t m_resp [3];
    axi_req_t  bus_req;
    axi_resp_t bus_resp;
    logic      busy;
    logic [1:0] grant_idx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_read_arbiter #(
        .NUM_MASTERS (3),
        .WRITE_MASTER(1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .m_axi_req   (m_req),
        .m_axi_resp  (m_resp),
        .bus_axi_req (bus_req),
        .bus_axi_resp(bus_resp),
        .busy        (busy),
        .grant_idx   (grant_idx)
    );

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task tick();
        @(posedge clk);
        #1;
    endtask

    task clear_inputs();
        for (int i = 0; i < 3; i++) m_req[i] = '0;
        bus_resp = '0;
    endtask

    task pulse_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        rst = 1'b0;
        #1;
    endtask

    // Stimulus only: finish a one-beat burst for master m, which must already be in ADDR.
    task finish_burst(input int m, input logic [31:0] data);
        m_req[m].rready  = 1'b1;
        bus_resp.arready = 1'b1;
        tick();
        bus_resp.arready = 1'b0;
        m_req[m].arvalid = 1'b0;
        bus_resp.rvalid  = 1'b1;
        bus_resp.rlast   = 1'b1;
        bus_resp.rdata   = data;
        tick();
        bus_resp.rvalid  = 1'b0;
        bus_resp.rlast   = 1'b0;
    endtask

    task test_reset();
        rst = 1'b1;
        clear_inputs();
        bus_resp.arready = 1'b1;
        bus_resp.rvalid  = 1'b1;
        bus_resp.rlast   = 1'b1;
        bus_resp.rdata   = 32'hDEAD_BEEF;
        m_req[0].arvalid = 1'b1;
        m_req[0].rready  = 1'b1;
        repeat (2) tick();
        if ({bus_req.arvalid, bus_req.rready, busy} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl got %b want 000", {bus_req.arvalid, bus_req.rready, busy});
        end
        checks++;
        if (grant_idx !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_grant got %0d want 0", grant_idx);
        end
        checks++;
        for (int i = 0; i < 3; i++) begin
            if ({m_resp[i].arready, m_resp[i].rvalid, m_resp[i].rlast, m_resp[i].rresp,
                 m_resp[i].rdata} !== 37'd0) begin
                errors++;
                $display("[TB] FAIL reset_resp%0d got rvalid=%b rdata=%h want zeros",
                         i, m_resp[i].rvalid, m_resp[i].rdata);
            end
            checks++;
        end
        clear_inputs();
        rst = 1'b0;
        tick();
    endtask

    task test_single();
        logic [31:0] exp_data;
        m_req[0].araddr  = 32'h1FC0_0000;
        m_req[0].arlen   = 8'd7;
        m_req[0].arsize  = 3'd2;
        m_req[0].arburst = 2'd1;
        m_req[0].rready  = 1'b1;
        m_req[0].arvalid = 1'b1;
        #1;
        if (bus_req.arvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_bubble got arvalid=%b want 0", bus_req.arvalid);
        end
        checks++;
        tick();
        if ({bus_req.arvalid, busy, grant_idx} !== {1'b1, 1'b1, 2'd0}) begin
            errors++;
            $display("[TB] FAIL single_grant got arvalid=%b busy=%b grant=%0d want 1 1 0",
                     bus_req.arvalid, busy, grant_idx);
        end
        checks++;
        if ({bus_req.araddr, bus_req.arlen, bus_req.arsize, bus_req.arburst} !==
            {32'h1FC0_0000, 8'd7, 3'd2, 2'd1}) begin
            errors++;
            $display("[TB] FAIL single_ar_fields got addr=%h len=%0d want 1fc00000 7",
                     bus_req.araddr, bus_req.arlen);
        end
        checks++;
        bus_resp.arready = 1'b1;
        #1;
        if ({m_resp[2].arready, m_resp[1].arready, m_resp[0].arready} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL single_arready got %b want 001",
                     {m_resp[2].arready, m_resp[1].arready, m_resp[0].arready});
        end
        checks++;
        tick();
        bus_resp.arready = 1'b0;
        m_req[0].arvalid = 1'b0;
        for (int b = 0; b < 8; b++) begin
            exp_data        = 32'hA000_0000 + 32'(b);
            bus_resp.rvalid = 1'b1;
            bus_resp.rdata  = exp_data;
            bus_resp.rlast  = (b == 7);
            #1;
            if ({m_resp[2].rvalid, m_resp[1].rvalid, m_resp[0].rvalid} !== 3'b001) begin
                errors++;
                $display("[TB] FAIL single_rvalid beat %0d got %b want 001", b,
                         {m_resp[2].rvalid, m_resp[1].rvalid, m_resp[0].rvalid});
            end
            checks++;
            if ({m_resp[0].rdata, m_resp[0].rlast} !== {exp_data, (b == 7)}) begin
                errors++;
                $display("[TB] FAIL single_rdata beat %0d got %h/%b want %h/%b", b,
                         m_resp[0].rdata, m_resp[0].rlast, exp_data, (b == 7));
            end
            checks++;
            tick();
        end
        bus_resp.rvalid = 1'b0;
        bus_resp.rlast  = 1'b0;
        #1;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_done got busy=%b want 0", busy);
        end
        checks++;
        m_req[0].arvalid = 1'b1;
        m_req[1].arvalid = 1'b1;
        tick();
        if (grant_idx !== 2'd1) begin
            errors++;
            $display("[TB] FAIL single_rrptr got grant=%0d want 1", grant_idx);
        end
        checks++;
    endtask

    task test_simultaneous();
        logic [31:0] exp_data;
        logic [31:0] exp_addr;
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            m_req[i].araddr  = 32'h1000 * 32'(i + 1);
            m_req[i].arlen   = 8'd3;
            m_req[i].rready  = 1'b1;
            m_req[i].arvalid = 1'b1;
        end
        for (int n = 0; n < 3; n++) begin
            bus_resp.rvalid = 1'b0;
            bus_resp.rlast  = 1'b0;
            #1;
            if ({bus_req.arvalid, busy} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL sim_bubble%0d got arvalid=%b busy=%b want 0 0",
                         n, bus_req.arvalid, busy);
            end
            checks++;
            tick();
            exp_addr = 32'h1000 * 32'(n + 1);
            if ({bus_req.arvalid, grant_idx, bus_req.araddr} !== {1'b1, 2'(n), exp_addr}) begin
                errors++;
                $display("[TB] FAIL sim_grant%0d got arvalid=%b grant=%0d addr=%h want 1 %0d %h",
                         n, bus_req.arvalid, grant_idx, bus_req.araddr, n, exp_addr);
            end
            checks++;
            bus_resp.arready = 1'b1;
            tick();
            bus_resp.arready = 1'b0;
            m_req[n].arvalid = 1'b0;
            for (int b = 0; b < 4; b++) begin
                exp_data        = 32'hB000_0000 + 32'(n * 16 + b);
                bus_resp.rvalid = 1'b1;
                bus_resp.rdata  = exp_data;
                bus_resp.rlast  = (b == 3);
                #1;
                if ({m_resp[2].rvalid, m_resp[1].rvalid, m_resp[0].rvalid} !== 3'(1 << n) ||
                    m_resp[n].rdata !== exp_data) begin
                    errors++;
                    $display("[TB] FAIL sim_beat m%0d b%0d got rvalid=%b data=%h want %b %h", n, b,
                             {m_resp[2].rvalid, m_resp[1].rvalid, m_resp[0].rvalid},
                             m_resp[n].rdata, 3'(1 << n), exp_data);
                end
                checks++;
                tick();
            end
        end
        bus_resp.rvalid = 1'b0;
        bus_resp.rlast  = 1'b0;
        #1;
        if ({busy, grant_idx} !== {1'b0, 2'd2}) begin
            errors++;
            $display("[TB] FAIL sim_end got busy=%b grant=%0d want 0 2", busy, grant_idx);
        end
        checks++;
    endtask

    task test_rr_wrap();
        pulse_reset();
        m_req[1].arvalid = 1'b1;
        tick();
        finish_burst(1, 32'h1111_0000);
        m_req[0].arvalid = 1'b1;
        m_req[2].arvalid = 1'b1;
        tick();
        if (grant_idx !== 2'd2) begin
            errors++;
            $display("[TB] FAIL rr_first got grant=%0d want 2", grant_idx);
        end
        checks++;
        m_req[1].arvalid = 1'b1;
        finish_burst(2, 32'h2222_0000);
        tick();
        if (grant_idx !== 2'd0) begin
            errors++;
            $display("[TB] FAIL rr_wrap got grant=%0d want 0", grant_idx);
        end
        checks++;
        finish_burst(0, 32'h0000_0000);
        tick();
        if (grant_idx !== 2'd1) begin
            errors++;
            $display("[TB] FAIL rr_next got grant=%0d want 1", grant_idx);
        end
        checks++;
        finish_burst(1, 32'h1111_0001);
    endtask

    task test_backpressure();
        pulse_reset();
        m_req[0].arvalid = 1'b1;
        m_req[0].rready  = 1'b1;
        tick();
        bus_resp.arready = 1'b1;
        tick();
        bus_resp.arready = 1'b0;
        m_req[0].arvalid = 1'b0;
        m_req[0].rready  = 1'b0;
        m_req[1].arvalid = 1'b1;
        bus_resp.rvalid  = 1'b1;
        bus_resp.rlast   = 1'b1;
        bus_resp.rdata   = 32'hC0DE_0001;
        #1;
        if ({bus_req.rready, m_resp[0].rvalid} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL bp_rready got rready=%b rvalid=%b want 0 1",
                     bus_req.rready, m_resp[0].rvalid);
        end
        checks++;
        for (int c = 0; c < 3; c++) begin
            tick();
            if ({busy, grant_idx, m_resp[0].rlast} !== {1'b1, 2'd0, 1'b1}) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d got busy=%b grant=%0d rlast=%b want 1 0 1",
                         c, busy, grant_idx, m_resp[0].rlast);
            end
            checks++;
        end
        m_req[0].rready = 1'b1;
        #1;
        if (bus_req.rready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_release got rready=%b want 1", bus_req.rready);
        end
        checks++;
        tick();
        bus_resp.rvalid = 1'b0;
        bus_resp.rlast  = 1'b0;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_done got busy=%b want 0", busy);
        end
        checks++;
        tick();
        if ({grant_idx, bus_req.arvalid} !== {2'd1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL bp_next got grant=%0d arvalid=%b want 1 1",
                     grant_idx, bus_req.arvalid);
        end
        checks++;
        finish_burst(1, 32'hC0DE_0002);
    endtask

    task test_isolation();
        pulse_reset();
        m_req[1].araddr  = 32'h8000_0040;
        m_req[1].arlen   = 8'd3;
        m_req[1].rready  = 1'b1;
        m_req[1].arvalid = 1'b1;
        m_req[2].araddr  = 32'hF000_0010;
        m_req[2].rready  = 1'b1;
        tick();
        m_req[2].arvalid = 1'b1;
        bus_resp.arready = 1'b1;
        #1;
        if ({m_resp[2].arready, m_resp[1].arready, grant_idx} !== {1'b0, 1'b1, 2'd1}) begin
            errors++;
            $display("[TB] FAIL iso_arready got m2=%b m1=%b grant=%0d want 0 1 1",
                     m_resp[2].arready, m_resp[1].arready, grant_idx);
        end
        checks++;
        tick();
        bus_resp.arready = 1'b0;
        m_req[1].arvalid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            bus_resp.rvalid = 1'b1;
            bus_resp.rdata  = 32'h5500_0000 + 32'(b);
            bus_resp.rlast  = (b == 3);
            #1;
            if ({m_resp[2].arready, m_resp[2].rvalid, m_resp[2].rlast, m_resp[1].rvalid} !==
                4'b0001) begin
                errors++;
                $display("[TB] FAIL iso_beat%0d got m2 ar/rv/rl=%b%b%b m1 rv=%b want 000 1", b,
                         m_resp[2].arready, m_resp[2].rvalid, m_resp[2].rlast, m_resp[1].rvalid);
            end
            checks++;
            tick();
        end
        bus_resp.rvalid = 1'b0;
        bus_resp.rlast  = 1'b0;
        #1;
        if ({bus_req.arvalid, m_resp[2].arready} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL iso_bubble got arvalid=%b m2 arready=%b want 0 0",
                     bus_req.arvalid, m_resp[2].arready);
        end
        checks++;
        tick();
        if ({grant_idx, bus_req.arvalid, bus_req.araddr} !== {2'd2, 1'b1, 32'hF000_0010}) begin
            errors++;
            $display("[TB] FAIL iso_m2_grant got grant=%0d arvalid=%b addr=%h want 2 1 f0000010",
                     grant_idx, bus_req.arvalid, bus_req.araddr);
        end
        checks++;
        finish_burst(2, 32'h7777_0000);
    endtask

    task test_reset_mid();
        pulse_reset();
        m_req[1].arvalid = 1'b1;
        tick();
        finish_burst(1, 32'h1234_0000);
        m_req[0].arlen   = 8'd7;
        m_req[0].rready  = 1'b1;
        m_req[0].arvalid = 1'b1;
        tick();
        bus_resp.arready = 1'b1;
        tick();
        bus_resp.arready = 1'b0;
        m_req[0].arvalid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            bus_resp.rvalid = 1'b1;
            bus_resp.rdata  = 32'h6600_0000 + 32'(b);
            tick();
        end
        bus_resp.rdata = 32'h6600_0002;
        #2;
        rst = 1'b1;
        #1;
        if ({bus_req.arvalid, bus_req.rready, busy, m_resp[0].rvalid} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL midreset_drop got arv/rrdy/busy/rv=%b want 0000",
                     {bus_req.arvalid, bus_req.rready, busy, m_resp[0].rvalid});
        end
        checks++;
        clear_inputs();
        tick();
        rst = 1'b0;
        m_req[0].rready  = 1'b1;
        m_req[2].rready  = 1'b1;
        m_req[0].arvalid = 1'b1;
        m_req[2].arvalid = 1'b1;
        tick();
        if ({grant_idx, bus_req.arvalid, busy} !== {2'd0, 1'b1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL midreset_regrant got grant=%0d arvalid=%b busy=%b want 0 1 1",
                     grant_idx, bus_req.arvalid, busy);
        end
        checks++;
        finish_burst(0, 32'h6600_0010);
        m_req[2].arvalid = 1'b0;
    endtask

    task test_write_passthrough();
        pulse_reset();
        m_req[1].awaddr  = 32'h4000_1000;
        m_req[1].awlen   = 8'd3;
        m_req[1].awvalid = 1'b1;
        m_req[1].wdata   = 32'hCAFE_F00D;
        m_req[1].wstrb   = 4'hF;
        m_req[1].wvalid  = 1'b1;
        m_req[1].bready  = 1'b1;
        m_req[0].awaddr  = 32'h0BAD_0BAD;
        m_req[0].awvalid = 1'b1;
        m_req[2].wdata   = 32'h1357_9BDF;
        #1;
        if ({bus_req.awaddr, bus_req.awlen, bus_req.awvalid, bus_req.wdata, bus_req.wstrb,
             bus_req.wvalid, bus_req.bready} !==
            {32'h4000_1000, 8'd3, 1'b1, 32'hCAFE_F00D, 4'hF, 1'b1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL wr_fwd got awaddr=%h wdata=%h awvalid=%b want 40001000 cafef00d 1",
                     bus_req.awaddr, bus_req.wdata, bus_req.awvalid);
        end
        checks++;
        bus_resp.awready = 1'b1;
        bus_resp.wready  = 1'b1;
        bus_resp.bvalid  = 1'b1;
        bus_resp.bresp   = 2'b10;
        #1;
        if ({m_resp[1].awready, m_resp[1].wready, m_resp[1].bvalid, m_resp[1].bresp} !==
            5'b11110) begin
            errors++;
            $display("[TB] FAIL wr_resp_m1 got %b want 11110",
                     {m_resp[1].awready, m_resp[1].wready, m_resp[1].bvalid, m_resp[1].bresp});
        end
        checks++;
        if ({m_resp[0].awready, m_resp[0].wready, m_resp[0].bvalid, m_resp[0].bresp,
             m_resp[2].awready, m_resp[2].wready, m_resp[2].bvalid, m_resp[2].bresp} !==
            10'd0) begin
            errors++;
            $display("[TB] FAIL wr_resp_others got m0 bvalid=%b m2 bvalid=%b want 0 0",
                     m_resp[0].bvalid, m_resp[2].bvalid);
        end
        checks++;
        clear_inputs();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single();
        test_simultaneous();
        test_rr_wrap();
        test_backpressure();
        test_isolation();
        test_reset_mid();
        test_write_passthrough();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
